button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 360000 (10 ms at 36 MHz), stable cycles required to accept a level change; legal range >= 2.
REQ-002 SHALL have parameter LONG_CYCLES, default 36000000 (1 s at 36 MHz), held cycles before a long-press event; SHALL be > DEBOUNCE_CYCLES.
REQ-003 CLK  input  1  system clock; all state on its rising edge.
REQ-004 RST_N  input  1  reset; asynchronous assert, active-low.
REQ-005 BTN_N  input  1  raw push-button pad; active-low (0 = pressed); asynchronous to CLK.
REQ-006 PRESSED  output  1  debounced level; 1 = button held.
REQ-007 PRESS_PULSE  output  1  one-cycle strobe on accepted press.
REQ-008 RELEASE_PULSE  output  1  one-cycle strobe on accepted release.
REQ-009 LONG_PULSE  output  1  one-cycle strobe when a press has been held LONG_CYCLES.

Function
REQ-010 BTN_N SHALL pass through a 2-flop synchronizer; the synchronized signal is s; all decisions use s only.
REQ-011 FSM states SHALL be IDLE, DB_PRESS, HELD, DB_RELEASE.
REQ-012 IDLE: s=0 -> DB_PRESS with debounce counter cleared to 0; else stay.
REQ-013 DB_PRESS: s=1 -> IDLE (glitch rejected, no output change); s=0 and counter = DEBOUNCE_CYCLES-1 -> HELD; else counter +1.
REQ-014 Entry to HELD from DB_PRESS SHALL set PRESSED=1 and assert PRESS_PULSE for exactly one cycle, both in the same cycle, and SHALL clear the hold counter.
REQ-015 Latency: if s first reads 0 in cycle t and stays 0, PRESS_PULSE SHALL be 1 in cycle t+DEBOUNCE_CYCLES; outputs are registered.
REQ-016 HELD: hold counter increments each cycle and saturates at LONG_CYCLES-1; the cycle it reaches LONG_CYCLES-1, LONG_PULSE SHALL assert once; no further LONG_PULSE until the next accepted press.
REQ-017 HELD: s=1 -> DB_RELEASE with debounce counter cleared; the hold counter keeps its value and keeps counting.
REQ-018 DB_RELEASE: s=0 -> HELD (bounce rejected, PRESSED stays 1, no pulses); s=1 and counter = DEBOUNCE_CYCLES-1 -> IDLE with PRESSED=0 and RELEASE_PULSE for one cycle; else counter +1.
REQ-019 If the hold counter reaches LONG_CYCLES-1 while in DB_RELEASE, LONG_PULSE SHALL still assert (once).
REQ-020 At most one of PRESS_PULSE, RELEASE_PULSE SHALL be high in any cycle; LONG_PULSE never coincides with PRESS_PULSE.
REQ-021 Counter widths SHALL be $clog2 of the respective parameter; no wrap-around is permitted.

Reset
REQ-022 RST_N=0 SHALL immediately force: synchronizer flops to 1 (released), state IDLE, both counters 0, PRESSED=0, all pulses 0.
REQ-023 Reset mid-press SHALL emit no RELEASE_PULSE; after release of reset with BTN_N held low, a fresh full debounce SHALL precede PRESS_PULSE.

Configuration
REQ-024 Macro BUTTON_LONG_PRESS_EN: defined -> hold counter and LONG_PULSE behaviour per REQ-016/019; undefined -> hold counter absent, LONG_PULSE tied 0, LONG_CYCLES ignored.

Structure
REQ-025 Package button_pkg SHALL hold the FSM state enum (IDLE, DB_PRESS, HELD, DB_RELEASE) and default-timing constants.
REQ-026 Sub-module sync2 (2-flop synchronizer, reset value parameterized) SHALL be instantiated for BTN_N.

Verification (bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-027 Clean press: BTN_N 1->0 held -> PRESS_PULSE exactly 1 cycle at 2+4 cycles after the pad edge, PRESSED=1 from then.
REQ-028 Glitch: BTN_N low for 3 cycles then high -> no pulse, PRESSED stays 0, FSM back to IDLE.
REQ-029 Release bounce: while PRESSED, BTN_N high 2 cycles, low 1, high steady -> single RELEASE_PULSE 4 cycles after the last rising s edge; no extra PRESS_PULSE.
REQ-030 Long press (macro defined): BTN_N low 40 cycles -> one LONG_PULSE 20 cycles after PRESS_PULSE, none more; macro undefined -> LONG_PULSE never 1.
REQ-031 Reset mid-press: RST_N pulsed low while PRESSED=1 -> PRESSED=0 immediately, no RELEASE_PULSE; BTN_N still low -> new PRESS_PULSE 6 cycles after RST_N deasserts.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and default timing for the push-button debouncer.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        HELD,
        DB_RELEASE
    } btn_state_t;

    // 10 ms and 1 s at a 36 MHz system clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = 360000;
    localparam int DEFAULT_LONG_CYCLES     = 36000000;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input; reset value is a parameter.
module sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {2{RESET_VALUE}};
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/button_debounce.sv
// Debounced active-low push button with registered press/release strobes.
// Define BUTTON_LONG_PRESS_EN to add the hold counter and long_pulse; otherwise long_pulse is 0.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
        $error("button_debounce: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
    end

    logic            s;
    btn_state_t      state_reg, state_next;
    logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
    logic            pressed_reg, pressed_next;
    logic            press_pulse_reg, press_pulse_next;
    logic            release_pulse_reg, release_pulse_next;

    // s == 0 means the button is currently seen as pressed
    sync2 #(.RESET_VALUE(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_n),
        .q     (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            db_cnt_reg        <= '0;
            pressed_reg       <= 1'b0;
            press_pulse_reg   <= 1'b0;
            release_pulse_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            db_cnt_reg        <= db_cnt_next;
            pressed_reg       <= pressed_next;
            press_pulse_reg   <= press_pulse_next;
            release_pulse_reg <= release_pulse_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        db_cnt_next        = db_cnt_reg;
        pressed_next       = pressed_reg;
        press_pulse_next   = 1'b0;
        release_pulse_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!s) begin
                    state_next  = DB_PRESS;
                    db_cnt_next = '0;
                end
            end
            DB_PRESS: begin
                if (s) begin
                    state_next = IDLE;
                end else if (db_cnt_reg == DB_LAST) begin
                    state_next       = HELD;
                    pressed_next     = 1'b1;
                    press_pulse_next = 1'b1;
                end else begin
                    db_cnt_next = db_cnt_reg + DB_W'(1);
                end
            end
            HELD: begin
                if (s) begin
                    state_next  = DB_RELEASE;
                    db_cnt_next = '0;
                end
            end
            DB_RELEASE: begin
                if (!s) begin
                    state_next = HELD;
                end else if (db_cnt_reg == DB_LAST) begin
                    state_next         = IDLE;
                    pressed_next       = 1'b0;
                    release_pulse_next = 1'b1;
                end else begin
                    db_cnt_next = db_cnt_reg + DB_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int                HOLD_W    = $clog2(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic              held_phase;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic              long_done_reg, long_done_next;
    logic              long_pulse_reg, long_pulse_next;

    assign held_phase = (state_reg == HELD) || (state_reg == DB_RELEASE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg   <= '0;
            long_done_reg  <= 1'b0;
            long_pulse_reg <= 1'b0;
        end else begin
            hold_cnt_reg   <= hold_cnt_next;
            long_done_reg  <= long_done_next;
            long_pulse_reg <= long_pulse_next;
        end
    end

    // The strobe fires once from the saturated count, even if the release
    // was accepted in the cycle the count saturated.
    always_comb begin
        hold_cnt_next   = hold_cnt_reg;
        long_done_next  = long_done_reg;
        long_pulse_next = 1'b0;
        if (press_pulse_next) begin
            hold_cnt_next  = '0;
            long_done_next = 1'b0;
        end else begin
            if (hold_cnt_reg == HOLD_LAST && !long_done_reg) begin
                long_pulse_next = 1'b1;
                long_done_next  = 1'b1;
            end
            if (held_phase && hold_cnt_reg != HOLD_LAST) begin
                hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
            end
        end
    end

    assign long_pulse = long_pulse_reg;
`else
    assign long_pulse = 1'b0;
`endif

    assign pressed       = pressed_reg;
    assign press_pulse   = press_pulse_reg;
    assign release_pulse = release_pulse_reg;

endmodule

// File: tb/tb_button_debounce.sv
// Randomised scoreboard bench for button_debounce (DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
// Long-press expectations follow BUTTON_LONG_PRESS_EN exactly as the design does.
module tb_button_debounce;

    localparam int DB = 4;
    localparam int LG = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_n = 1'b1;
    logic pressed, press_pulse, release_pulse, long_pulse;

    button_debounce #(.DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_n         (btn_n),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  last_cyc[3] = '{-1, -1, -1};
    int  n_ev[3] = '{0, 0, 0};

    // Reference model: button level seen through a two-sample delay; a level
    // change is accepted after DB+1 consecutive contrary samples.
    bit  b1 = 1'b1, b2 = 1'b1, lvl = 1'b0, long_armed = 1'b0;
    int  run = 0;
    int  press_edge = 0;

    function automatic string kname(input int k);
        case (k)
            0:       return "press";
            1:       return "release";
            default: return "long";
        endcase
    endfunction

    task automatic push_ev(input int k);
        ev_t e;
        e.kind = k;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        b1 = 1'b1; b2 = 1'b1; lvl = 1'b0; run = 0; long_armed = 1'b0;
    endtask

    initial begin
        bit s;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                model_reset();
            end else begin
                s  = b2;
                b2 = b1;
                b1 = btn_n;
                if ((s == 1'b0) != lvl) run++;
                else run = 0;
                if (run == DB + 1) begin
                    run = 0;
                    lvl = !lvl;
                    if (lvl) begin
                        push_ev(0);
                        press_edge = cyc;
                        long_armed = 1'b1;
                    end else begin
                        push_ev(1);
                        if (cyc < press_edge + LG - 1) long_armed = 1'b0;
                    end
                end
`ifdef BUTTON_LONG_PRESS_EN
                if (long_armed && cyc == press_edge + LG) begin
                    push_ev(2);
                    long_armed = 1'b0;
                end
`endif
            end
        end
    end

    // Monitor: every DUT strobe must match a queued expectation for this cycle.
    initial begin
        logic [2:0] v;
        int idx;
        forever begin
            @(negedge clk);
            checks++;
            if (pressed !== lvl) begin
                errors++;
                $display("FAIL pressed level @%0d: got %b required %b", cyc, pressed, lvl);
            end
            v = {long_pulse, release_pulse, press_pulse};
            for (int k = 0; k < 3; k++) begin
                if (v[k] === 1'b1) begin
                    $display("cycle %0d: %s pulse", cyc, kname(k));
                    last_cyc[k] = cyc;
                    n_ev[k]++;
                    idx = -1;
                    foreach (exp_q[i]) if (exp_q[i].kind == k && exp_q[i].cyc == cyc) idx = i;
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL %s pulse @%0d: got 1 required 0", kname(k), cyc);
                    end else begin
                        exp_q.delete(idx);
                    end
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL %s pulse @%0d: got 0 required 1", kname(exp_q[0].kind), exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic expect_eq(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    initial begin
        int e, np, nr, nl;

        rst_n = 1'b0;
        btn_n = 1'b1;
        step(3);
        expect_eq("reset pressed", int'(pressed), 0);
        expect_eq("reset press_pulse", int'(press_pulse), 0);
        expect_eq("reset release_pulse", int'(release_pulse), 0);
        expect_eq("reset long_pulse", int'(long_pulse), 0);
        rst_n = 1'b1;
        step(5);

        // Clean press and release: strobes land 6 edges after the pad edge
        btn_n = 1'b0;
        e = cyc + 1;
        step(12);
        expect_eq("press latency", last_cyc[0], e + 6);
        expect_eq("pressed after press", int'(pressed), 1);
        btn_n = 1'b1;
        e = cyc + 1;
        step(12);
        expect_eq("release latency", last_cyc[1], e + 6);
        expect_eq("pressed after release", int'(pressed), 0);

        // Glitch shorter than the debounce window
        np = n_ev[0];
        btn_n = 1'b0;
        step(3);
        btn_n = 1'b1;
        step(10);
        expect_eq("glitch press count", n_ev[0], np);
        expect_eq("glitch pressed", int'(pressed), 0);

        // Release with bounce
        btn_n = 1'b0;
        step(10);
        np = n_ev[0];
        nr = n_ev[1];
        btn_n = 1'b1; step(2);
        btn_n = 1'b0; step(1);
        btn_n = 1'b1;
        e = cyc + 1;
        step(10);
        expect_eq("bounce release latency", last_cyc[1], e + 6);
        expect_eq("bounce release count", n_ev[1], nr + 1);
        expect_eq("bounce press count", n_ev[0], np);

        // Long press
        nl = n_ev[2];
        btn_n = 1'b0;
        e = cyc + 1;
        step(40);
`ifdef BUTTON_LONG_PRESS_EN
        expect_eq("long latency", last_cyc[2], e + 6 + LG);
        expect_eq("long count", n_ev[2], nl + 1);
`else
        expect_eq("long count disabled", n_ev[2], 0);
`endif
        btn_n = 1'b1;
        step(10);

        // Reset while held
        btn_n = 1'b0;
        step(12);
        expect_eq("pressed before reset", int'(pressed), 1);
        nr = n_ev[1];
        rst_n = 1'b0;
        #1;
        expect_eq("pressed during reset", int'(pressed), 0);
        step(2);
        rst_n = 1'b1;
        e = cyc + 1;
        step(12);
        expect_eq("reset release count", n_ev[1], nr);
        expect_eq("press after reset", last_cyc[0], e + 6);
        btn_n = 1'b1;
        step(12);

        // Random pad activity with occasional resets
        repeat (150) begin
            btn_n = 1'($urandom_range(0, 1));
            step($urandom_range(1, 30));
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                step($urandom_range(1, 3));
                rst_n = 1'b1;
            end
        end
        btn_n = 1'b1;
        step(30);
        expect_eq("pending expectations", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
